// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and sizing for the multi-word add sequencer
package add_seq_pkg;
    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_WORDS = 4;
    function automatic int cnt_w(input int words);
        return $clog2(words + 1);
    endfunction
    localparam int CNT_W = cnt_w(SEQ_WORDS);
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic [SEQ_WIDTH-1:0] a;
        logic [SEQ_WIDTH-1:0] b;
        logic                 first;
        logic                 last;
        logic                 cin;
    } s1_t;
endpackage

// File: rtl/add_word_sequencer.sv
// add_word_sequencer: streams word pairs through an external adder, chaining carries across words
module add_word_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int WORDS = SEQ_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             err
);
    localparam int CW = cnt_w(WORDS);
    state_t        state, state_d;
    logic [CW-1:0] word_cnt, cnt_d, idx;
    s1_t           s1, s1_d;
    logic          s1_valid, carry_reg, s1_adv, acc, start, force_last, last_eff, err_d;
    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s1_adv;
    assign acc      = in_valid & in_ready;
    assign add_a    = s1.a;
    assign add_b    = s1.b;
    assign add_cin  = s1.first ? s1.cin : carry_reg;
    // a word arriving in IDLE always opens an operand, with or without in_first
    always_comb begin
        start      = (state == IDLE) | in_first;
        idx        = start ? CW'(1) : word_cnt + CW'(1);
        force_last = ~in_last & (idx == CW'(WORDS));
        last_eff   = in_last | force_last;
        err_d      = acc & (((state == IDLE) & ~in_first) | ((state == BUSY) & in_first) | force_last);
        state_d    = acc ? (last_eff ? IDLE : BUSY) : state;
        cnt_d      = acc ? (last_eff ? '0 : idx) : word_cnt;
        s1_d       = '{a: in_a, b: in_b, first: start, last: last_eff, cin: in_first & in_cin};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            s1        <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            carry_reg <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_d;
            word_cnt <= cnt_d;
            err      <= err_d;
            if (acc) begin
                s1       <= s1_d;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                out_valid <= 1'b1;
                out_sum   <= add_sum;
                out_last  <= s1.last;
                out_cout  <= s1.last & add_cout;
                carry_reg <= add_cout;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_word_sequencer.sv
// tb_add_word_sequencer: directed and random checks of the sequencer against an operand-level model
module tb_add_word_sequencer;
    localparam int WORDS = 4;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_first, in_last, in_cin;
    logic       add_cin, add_cout, out_valid, out_ready, out_last, out_cout, err;
    logic [7:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
    int         errors = 0;
    int         checks = 0;
    bit         rnd_ready = 0;
    typedef struct {
        logic [7:0] sum;
        bit         last;
        bit         cout;
    } exp_t;
    exp_t   exp_q[$];
    bit     busy = 0;
    bit     mcin = 0;
    longint op_a = 0;
    longint op_b = 0;
    int     n_w = 0;

    add_word_sequencer #(.WIDTH(8), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
        .out_cout(out_cout), .err(err)
    );

    assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // operand-level reference: each output word is a slice of the full-width sum of the prefix so far
    task automatic model_accept(input logic [7:0] a, b, input bit f, l, c, output bit e);
        longint tot;
        bit     fl;
        e = 0;
        if (!busy || f) begin
            e    = (!busy && !f) || (busy && f);
            op_a = 0;
            op_b = 0;
            n_w  = 0;
            mcin = f ? c : 1'b0;
        end
        op_a = op_a | (longint'(a) << (8 * n_w));
        op_b = op_b | (longint'(b) << (8 * n_w));
        n_w++;
        fl   = !l && (n_w == WORDS);
        e    = e | fl;
        tot  = op_a + op_b + longint'(mcin);
        exp_q.push_back('{sum: 8'(tot >> (8 * (n_w - 1))), last: l | fl, cout: (l | fl) & tot[8 * n_w]});
        busy = !(l | fl);
    endtask

    task automatic cycle(output bit acc);
        bit   fire, e;
        exp_t x;
        if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
        #1;
        acc  = rst_n && in_valid && in_ready;
        fire = rst_n && out_valid && out_ready;
        e    = 0;
        if (fire) begin
            chk("word_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(x.sum));
                chk("out_last", 32'(out_last), 32'(x.last));
                chk("out_cout", 32'(out_cout), 32'(x.cout));
            end
        end
        if (acc) model_accept(in_a, in_b, in_first, in_last, in_cin, e);
        @(posedge clk);
        #1;
        chk("err", 32'(err), 32'(e));
    endtask

    task automatic send_word(input logic [7:0] a, b, input bit f, l, c, output int n);
        bit acc;
        in_valid = 1;
        in_a     = a;
        in_b     = b;
        in_first = f;
        in_last  = l;
        in_cin   = c;
        n        = 0;
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        bit acc;
        int t = 0;
        in_valid  = 0;
        out_ready = 1;
        while (exp_q.size() != 0 && t < 40) begin
            cycle(acc);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        cycle(acc);
        chk("drain_idle", 32'(out_valid), 0);
    endtask

    initial begin
        int n;
        bit acc;
        rst_n     = 0;
        in_valid  = 0;
        in_a      = 0;
        in_b      = 0;
        in_first  = 0;
        in_last   = 0;
        in_cin    = 0;
        out_ready = 0;
        repeat (2) cycle(acc);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_add_cin", 32'(add_cin), 0);
        rst_n     = 1;
        out_ready = 1;

        send_word(8'hFF, 8'h01, 1, 0, 0, n);
        send_word(8'h01, 8'h00, 0, 1, 0, n);
        chk("t1_w0_sum", 32'(out_sum), 'h00);
        cycle(acc);
        chk("t1_w1_sum", 32'(out_sum), 'h02);
        chk("t1_w1_last", 32'(out_last), 1);
        chk("t1_w1_cout", 32'(out_cout), 0);
        drain();

        send_word(8'hFF, 8'h01, 1, 0, 0, n);
        chk("lat_edge1", 32'(out_valid), 0);
        send_word(8'hFF, 8'h00, 0, 0, 0, n);
        chk("lat_edge2", 32'(out_valid), 1);
        send_word(8'hFF, 8'h00, 0, 0, 0, n);
        chk("b2b_w2", n, 1);
        send_word(8'hFF, 8'h00, 0, 1, 0, n);
        chk("b2b_w3", n, 1);
        cycle(acc);
        cycle(acc);
        chk("t2_cout", 32'(out_cout), 1);
        drain();

        send_word(8'hFF, 8'h01, 1, 0, 0, n);
        send_word(8'hFF, 8'h00, 0, 0, 0, n);
        out_ready = 0;
        in_valid  = 1;
        in_a      = 8'hFF;
        in_b      = 8'h00;
        in_first  = 0;
        in_last   = 0;
        repeat (3) begin
            cycle(acc);
            chk("stall_accept", 32'(acc), 0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_sum", 32'(out_sum), 32'(exp_q[0].sum));
        end
        out_ready = 1;
        send_word(8'hFF, 8'h00, 0, 0, 0, n);
        send_word(8'hFF, 8'h00, 0, 1, 0, n);
        drain();

        send_word(8'h80, 8'h80, 1, 1, 1, n);
        cycle(acc);
        chk("single_sum", 32'(out_sum), 'h01);
        chk("single_last", 32'(out_last), 1);
        chk("single_cout", 32'(out_cout), 1);
        drain();

        send_word(8'h11, 8'h22, 1, 0, 0, n);
        send_word(8'h33, 8'h44, 0, 0, 0, n);
        send_word(8'h55, 8'h66, 0, 0, 0, n);
        send_word(8'h77, 8'h99, 0, 0, 0, n);
        chk("force_err", 32'(err), 1);
        send_word(8'hF0, 8'h10, 0, 0, 1, n);
        chk("restart_err", 32'(err), 1);
        send_word(8'hFF, 8'h00, 1, 0, 1, n);
        chk("first_busy_err", 32'(err), 1);
        send_word(8'h01, 8'h02, 0, 1, 0, n);
        chk("clean_word_err", 32'(err), 0);
        drain();

        send_word(8'hFF, 8'hFF, 1, 0, 1, n);
        send_word(8'h12, 8'h34, 0, 0, 0, n);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 0;
        cycle(acc);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sum", 32'(out_sum), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        chk("mid_rst_cout", 32'(out_cout), 0);
        chk("mid_rst_add", 32'({add_a, add_b, add_cin}), 0);
        exp_q.delete();
        busy  = 0;
        rst_n = 1;
        send_word(8'hFF, 8'h01, 0, 0, 0, n);
        send_word(8'h01, 8'h00, 0, 1, 0, n);
        drain();

        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            int len  = $urandom_range(1, 5);
            int kind = $urandom_range(0, 7);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) cycle(acc);
                send_word(8'($urandom), 8'($urandom), (w == 0) && (kind != 0),
                          (w == len - 1) && (kind != 1), 1'($urandom), n);
            end
        end
        rnd_ready = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
